layer_compositor: RTL
=====================

Name: layer_compositor

Overview:
- Parametrised N-layer pixel colour compositor.
- Replaces the fixed combinational priority chain in the top level (starboy > score > moving grid > held grid).
- Registered 2-stage pipeline with per-layer enable, frame-synchronous per-layer blinking, and a background colour.
- Sits between the layer renderers and vgadriver color_in.

Parameters:
- NUM_LAYERS, 4, number of input layers; layer 0 has the highest priority.
- COLOR_W, 3, bits per colour (3 = {R,G,B}).
- BLINK_DIV, 30, frame_start pulses per blink half-period (minimum 1).
- TRANSPARENT, 0, colour value treated as "no pixel" on any layer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- pix_valid  in  1  current x/y is inside the active display area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- layer_colors  in  NUM_LAYERS*COLOR_W  layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  per-layer enable; 0 forces the layer transparent.
- blink_mask  in  NUM_LAYERS  1 means the layer blinks.
- bg_color  in  COLOR_W  colour used when no layer is opaque.
- color_out  out  COLOR_W  composited colour.
- color_valid  out  1  color_out corresponds to a valid pixel.
- winner_idx  out  $clog2(NUM_LAYERS)+1  index of the selected layer; value NUM_LAYERS means background.
- blink_phase  out  1  current blink phase; 1 means blinking layers are hidden.

Behaviour:
- Reset (rst_n=0 at a clk edge), applied on the same edge:
  - color_out=0, color_valid=0, winner_idx=NUM_LAYERS, blink_phase=0.
  - Frame counter and all pipeline registers cleared.
  - Reset mid-frame discards all in-flight pixels.
- Stage 1 (edge n): registers pix_valid, layer_colors, and the effective mask. Per layer, eff_opaque[i] = layer_en[i] & (color_i != TRANSPARENT) & ~(blink_mask[i] & blink_phase).
- Stage 2 (edge n+1):
  - Selects the lowest i with eff_opaque[i]=1 and outputs that colour and index.
  - If no layer is opaque, outputs bg_color with winner_idx=NUM_LAYERS.
  - If the stage-1 pix_valid=0, outputs color_out=0, color_valid=0, winner_idx=NUM_LAYERS.
- Latency: inputs sampled at edge n appear on the outputs after edge n+1 (2 cycles). Throughput: 1 pixel per clock, no stalls.
- Blink counter:
  - Width $clog2(BLINK_DIV)+1; advances only on frame_start.
  - On frame_start with count==BLINK_DIV-1: count becomes 0 and blink_phase toggles. Otherwise count increments.
  - With BLINK_DIV=1, blink_phase toggles on every frame_start.
- Blink timing: stage 1 uses the registered blink_phase value from before the edge. A pixel presented in the same cycle as frame_start therefore uses the old phase.
- Signals with no handshake: layer_en, blink_mask and bg_color are sampled every cycle and may change at any time.
- bg_color is registered in stage 1 alongside the pixel it applies to.
- All internal arithmetic is unsigned. No state other than the pipeline and blink counter.

Optional Feature:
- Macro: LAYER_COLLISION_EN.
- When defined, the block adds:
  - Output port collision (1 bit), with the same 2-cycle latency. It is 1 when two or more layers are eff_opaque on a valid pixel.
  - Output port collision_seen (1 bit). It is sticky, set by any collision, and cleared on the edge where frame_start=1. That clear takes priority over a set in the same cycle. Both ports reset to 0.
- When undefined: neither port exists, and no collision logic is synthesised.

Test Plan:
1. NUM_LAYERS=4, COLOR_W=3, all enabled, pix_valid=1, layers = {L0=0, L1=3'b100, L2=3'b010, L3=3'b001}, bg=3'b111 -> two cycles later color_out=3'b100, winner_idx=1, color_valid=1.
2. All layers 0, bg_color=3'b011 -> color_out=3'b011, winner_idx=4. Then pix_valid=0 -> color_out=0, color_valid=0, winner_idx=4 after 2 cycles.
3. layer_en=4'b1110 with L0=3'b110 and L1=3'b101 -> color_out=3'b101, winner_idx=1 (L0 disabled).
4. BLINK_DIV=2, blink_mask=4'b0001, L0=3'b110, L1=3'b001:
   - blink_phase toggles to 1 after the 2nd frame_start pulse; color_out switches to 3'b001, winner_idx=1.
   - After the 4th pulse blink_phase=0 and color_out returns to 3'b110.
   - frame_start in the same cycle as a pixel -> that pixel uses the pre-toggle phase.
5. Assert rst_n=0 for 1 cycle mid-stream, with blink_phase=1 and a valid pixel in flight -> next edge: color_out=0, color_valid=0, blink_phase=0, winner_idx=4. The first valid output appears 2 cycles after the first valid input following reset.
6. With LAYER_COLLISION_EN, L0=3'b100 and L2=3'b010, both enabled -> collision=1 and collision_seen=1. Then layers cleared, frame_start pulse -> collision_seen=0. Without the macro, the module has no collision ports.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority pixel compositor, 2-stage pipeline with frame-synchronous blink.
// Define LAYER_COLLISION_EN to add the collision / collision_seen outputs.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W = 3,
    parameter int BLINK_DIV = 30,
    parameter int TRANSPARENT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_valid,
    input  logic frame_start,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_colors,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [NUM_LAYERS-1:0] blink_mask,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [COLOR_W-1:0] color_out,
    output logic color_valid,
    output logic [$clog2(NUM_LAYERS):0] winner_idx,
`ifdef LAYER_COLLISION_EN
    output logic collision,
    output logic collision_seen,
`endif
    output logic blink_phase
);
    localparam int IDX_W = $clog2(NUM_LAYERS) + 1;
    localparam int CNT_W = $clog2(BLINK_DIV) + 1;
    localparam logic [COLOR_W-1:0] TC = COLOR_W'(TRANSPARENT);
    localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

    logic [CNT_W-1:0] cnt;
    logic last;
    logic [NUM_LAYERS-1:0] eff;
    logic s1_valid;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_colors;
    logic [NUM_LAYERS-1:0] s1_mask;
    logic [COLOR_W-1:0] s1_bg;
    logic [COLOR_W-1:0] sel_col;
    logic [IDX_W-1:0] sel_idx;

    assign last = cnt == CNT_W'(BLINK_DIV - 1);

    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
            blink_phase <= blink_phase ^ last;
        end

    // Uses the phase from before this edge, so a pixel coincident with frame_start sees the old phase.
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            eff[i] = layer_en[i] & (layer_colors[i*COLOR_W +: COLOR_W] != TC) & ~(blink_mask[i] & blink_phase);
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_colors <= '0;
            s1_mask <= '0;
            s1_bg <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_colors <= layer_colors;
            s1_mask <= eff;
            s1_bg <= bg_color;
        end

    // Scan from lowest priority upward so the lowest opaque index wins.
    always_comb begin
        sel_col = s1_bg;
        sel_idx = BG_IDX;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (s1_mask[i]) begin
                sel_col = s1_colors[i*COLOR_W +: COLOR_W];
                sel_idx = IDX_W'(i);
            end
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            color_out <= '0;
            color_valid <= 1'b0;
            winner_idx <= BG_IDX;
        end else begin
            color_out <= s1_valid ? sel_col : '0;
            color_valid <= s1_valid;
            winner_idx <= s1_valid ? sel_idx : BG_IDX;
        end

`ifdef LAYER_COLLISION_EN
    logic coll;

    assign coll = s1_valid && ($countones(s1_mask) > 1);

    always_ff @(posedge clk)
        if (!rst_n) begin
            collision <= 1'b0;
            collision_seen <= 1'b0;
        end else begin
            collision <= coll;
            collision_seen <= frame_start ? 1'b0 : (collision_seen | coll);
        end
`endif
endmodule
